// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, line count default, I/O region constant and FSM states.
package icache_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ICACHE_LINES = 256;
  localparam int PHYS_MSB = 17;
  localparam logic [1:0] IO_REGION = 2'b11;
  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;
  function automatic logic is_io(input logic [1:0] region);
    return region == IO_REGION;
  endfunction
endpackage

// File: rtl/icache_mem.sv
// icache_mem: valid/tag/data arrays, combinational read, synchronous write; only valid bits reset.
module icache_mem
  import icache_pkg::*;
#(
  parameter int LINES = 256,
  parameter int INDEX_W = 8,
  parameter int TAG_W = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_W-1:0]    rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  we,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [DATA_WIDTH-1:0] data [LINES];
  assign rd_valid = valid[rd_index];
  assign rd_tag = tags[rd_index];
  assign rd_data = data[rd_index];
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) valid <= '0;
    else if (we) valid[wr_index] <= 1'b1;
  always_ff @(posedge clk_in)
    if (we) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-line instruction cache between IF and MemCtrl.
// Define ICACHE_EN to build the arrays and hit path; otherwise every fetch goes to MemCtrl.
module icache
  import icache_pkg::*;
#(
  parameter int LINES = ICACHE_LINES
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rdy_inst_if_in,
  input  logic [ADDR_WIDTH-1:0] inst_addr_if_in,
  output logic [DATA_WIDTH-1:0] inst_if_out,
  output logic                  rdy_inst_if_out,
  output logic                  rdy_inst_mc_out,
  output logic [ADDR_WIDTH-1:0] inst_addr_mc_out,
  input  logic [DATA_WIDTH-1:0] inst_mc_in,
  input  logic                  rdy_inst_mc_in,
  input  logic                  refresh_rob_cdb_in
);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W = PHYS_MSB + 1 - INDEX_W - 2;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] inst_n, rd_data;
  logic [ADDR_WIDTH-1:0] mc_addr_n;
  logic if_rdy_n, mc_rdy_n, hit;
`ifdef ICACHE_EN
  logic rd_valid, fill;
  logic [TAG_W-1:0] rd_tag;
  // A fill also lands when refresh coincides with the MemCtrl reply: the word matches its address.
  assign fill = rdy_in && state == MISS && rdy_inst_mc_in && !is_io(inst_addr_mc_out[PHYS_MSB -: 2]);
  assign hit = rd_valid && rd_tag == inst_addr_if_in[PHYS_MSB:INDEX_W+2];
  icache_mem #(.LINES(LINES), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_mem (
    .clk_in,
    .rst_in,
    .rd_index(inst_addr_if_in[INDEX_W+1:2]),
    .rd_valid,
    .rd_tag,
    .rd_data,
    .we(fill),
    .wr_index(inst_addr_mc_out[INDEX_W+1:2]),
    .wr_tag(inst_addr_mc_out[PHYS_MSB:INDEX_W+2]),
    .wr_data(inst_mc_in)
  );
`else
  assign hit = 1'b0;
  assign rd_data = '0;
`endif
  always_comb begin
    state_n = state;
    if_rdy_n = 1'b0;
    inst_n = inst_if_out;
    mc_rdy_n = rdy_inst_mc_out;
    mc_addr_n = inst_addr_mc_out;
    if (refresh_rob_cdb_in) begin
      state_n = IDLE;
      mc_rdy_n = 1'b0;
    end else
      case (state)
        IDLE:
          if (rdy_inst_if_in) begin
            state_n = hit ? RESP : MISS;
            if_rdy_n = hit;
            inst_n = hit ? rd_data : inst_if_out;
            mc_rdy_n = !hit;
            mc_addr_n = hit ? inst_addr_mc_out : inst_addr_if_in & ~32'h3;
          end
        MISS:
          if (rdy_inst_mc_in) begin
            state_n = RESP;
            mc_rdy_n = 1'b0;
            if_rdy_n = 1'b1;
            inst_n = inst_mc_in;
          end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state <= IDLE;
      rdy_inst_if_out <= 1'b0;
      inst_if_out <= '0;
      rdy_inst_mc_out <= 1'b0;
      inst_addr_mc_out <= '0;
    end else if (rdy_in) begin
      state <= state_n;
      rdy_inst_if_out <= if_rdy_n;
      inst_if_out <= inst_n;
      rdy_inst_mc_out <= mc_rdy_n;
      inst_addr_mc_out <= mc_addr_n;
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache; expectations adapt to ICACHE_EN.
module tb_icache;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic rdy_inst_if_in = 1'b0, rdy_inst_mc_in = 1'b0, refresh_rob_cdb_in = 1'b0;
  logic [31:0] inst_addr_if_in = '0, inst_mc_in = '0;
  logic [31:0] inst_if_out, inst_addr_mc_out;
  logic rdy_inst_if_out, rdy_inst_mc_out;
  int n_checks = 0, n_fail = 0;
`ifdef ICACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif
  always #5 clk_in = ~clk_in;
  icache dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .rdy_inst_if_in(rdy_inst_if_in),
    .inst_addr_if_in(inst_addr_if_in),
    .inst_if_out(inst_if_out),
    .rdy_inst_if_out(rdy_inst_if_out),
    .rdy_inst_mc_out(rdy_inst_mc_out),
    .inst_addr_mc_out(inst_addr_mc_out),
    .inst_mc_in(inst_mc_in),
    .rdy_inst_mc_in(rdy_inst_mc_in),
    .refresh_rob_cdb_in(refresh_rob_cdb_in)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, ".if_rdy"}, 32'(rdy_inst_if_out), 32'd0);
    chk({tag, ".inst"}, inst_if_out, 32'd0);
    chk({tag, ".mc_rdy"}, 32'(rdy_inst_mc_out), 32'd0);
    chk({tag, ".mc_addr"}, inst_addr_mc_out, 32'd0);
  endtask
  // Full fetch; want_hit only counts when the cache is built in.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data, input bit want_hit);
    bit hit;
    hit = want_hit && CACHE_ON;
    rdy_inst_if_in = 1'b1;
    inst_addr_if_in = addr;
    tick();
    chk({tag, ".first_if_rdy"}, 32'(rdy_inst_if_out), 32'(hit));
    chk({tag, ".first_mc_rdy"}, 32'(rdy_inst_mc_out), 32'(!hit));
    if (!hit) begin
      chk({tag, ".mc_addr"}, inst_addr_mc_out, addr & ~32'h3);
      tick(2);
      chk({tag, ".mc_hold"}, 32'(rdy_inst_mc_out), 32'd1);
      chk({tag, ".if_wait"}, 32'(rdy_inst_if_out), 32'd0);
      rdy_inst_mc_in = 1'b1;
      inst_mc_in = data;
      tick();
      rdy_inst_mc_in = 1'b0;
      inst_mc_in = '0;
      chk({tag, ".mc_drop"}, 32'(rdy_inst_mc_out), 32'd0);
      chk({tag, ".resp_if_rdy"}, 32'(rdy_inst_if_out), 32'd1);
    end
    chk({tag, ".inst"}, inst_if_out, data);
    rdy_inst_if_in = 1'b0;
    tick();
    chk({tag, ".pulse_end"}, 32'(rdy_inst_if_out), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tick(2);
    check_idle_outputs("reset");
    rst_in = 1'b0;
    tick();
    fetch("cold_miss", 32'h10, 32'h00500093, 1'b0);
    fetch("hit", 32'h10, 32'h00500093, 1'b1);
    fetch("conflict", 32'h410, 32'h11111111, 1'b0);
    fetch("evicted", 32'h10, 32'h00500093, 1'b0);
    fetch("rehit", 32'h10, 32'h00500093, 1'b1);
    rdy_inst_if_in = 1'b1;
    inst_addr_if_in = 32'h20;
    tick();
    chk("flush.mc_rdy_up", 32'(rdy_inst_mc_out), 32'd1);
    tick();
    refresh_rob_cdb_in = 1'b1;
    rdy_inst_if_in = 1'b0;
    tick();
    refresh_rob_cdb_in = 1'b0;
    chk("flush.mc_drop", 32'(rdy_inst_mc_out), 32'd0);
    chk("flush.no_if", 32'(rdy_inst_if_out), 32'd0);
    tick();
    chk("flush.idle_mc", 32'(rdy_inst_mc_out), 32'd0);
    chk("flush.idle_if", 32'(rdy_inst_if_out), 32'd0);
    fetch("after_flush", 32'h40, 32'hdeadbeef, 1'b0);
    fetch("flushed_not_filled", 32'h20, 32'h22222222, 1'b0);
    rdy_inst_if_in = 1'b1;
    inst_addr_if_in = 32'h50;
    tick();
    refresh_rob_cdb_in = 1'b1;
    rdy_inst_mc_in = 1'b1;
    inst_mc_in = 32'h55555555;
    rdy_inst_if_in = 1'b0;
    tick();
    refresh_rob_cdb_in = 1'b0;
    rdy_inst_mc_in = 1'b0;
    inst_mc_in = '0;
    chk("flush_fill.no_if", 32'(rdy_inst_if_out), 32'd0);
    chk("flush_fill.mc_drop", 32'(rdy_inst_mc_out), 32'd0);
    tick();
    fetch("flush_fill.hit", 32'h50, 32'h55555555, 1'b1);
    fetch("io_first", 32'h30000, 32'haaaa0001, 1'b0);
    fetch("io_second", 32'h30000, 32'haaaa0002, 1'b0);
    fetch("low_bits_ignored", 32'h13, 32'h00500093, 1'b1);
    fetch("high_bits_ignored", 32'h80000010, 32'h00500093, 1'b1);
    rdy_inst_if_in = 1'b1;
    inst_addr_if_in = 32'h60;
    tick();
    chk("freeze.mc_rdy_up", 32'(rdy_inst_mc_out), 32'd1);
    rdy_in = 1'b0;
    tick(2);
    rdy_inst_mc_in = 1'b1;
    inst_mc_in = 32'h66666666;
    tick();
    rdy_inst_mc_in = 1'b0;
    inst_mc_in = '0;
    tick(2);
    chk("freeze.mc_held", 32'(rdy_inst_mc_out), 32'd1);
    chk("freeze.addr_held", inst_addr_mc_out, 32'h60);
    chk("freeze.no_if", 32'(rdy_inst_if_out), 32'd0);
    rdy_in = 1'b1;
    rdy_inst_mc_in = 1'b1;
    inst_mc_in = 32'h66666666;
    tick();
    rdy_inst_mc_in = 1'b0;
    inst_mc_in = '0;
    chk("freeze.resp", 32'(rdy_inst_if_out), 32'd1);
    rdy_in = 1'b0;
    tick(2);
    chk("freeze.pulse_held", 32'(rdy_inst_if_out), 32'd1);
    chk("freeze.inst_held", inst_if_out, 32'h66666666);
    rdy_in = 1'b1;
    rdy_inst_if_in = 1'b0;
    tick();
    chk("freeze.pulse_end", 32'(rdy_inst_if_out), 32'd0);
    rdy_inst_if_in = 1'b1;
    inst_addr_if_in = 32'h70;
    tick();
    chk("rst_mid.mc_rdy_up", 32'(rdy_inst_mc_out), 32'd1);
    rst_in = 1'b1;
    #2;
    check_idle_outputs("rst_mid");
    #2;
    rst_in = 1'b0;
    rdy_inst_if_in = 1'b0;
    tick();
    fetch("after_reset", 32'h10, 32'h00500093, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
